traffic_light_controller: RTL and testbench



---
 rtl/traffic_light_controller.sv | 46 ++++
 tb/tb_traffic_light_controller.sv | 93 +++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: fixed-time six-phase Moore controller for a T-junction
module traffic_light_controller #(
  parameter int T_MAIN = 7,
  parameter int T_YEL  = 2,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  typedef enum logic [2:0] {S1, S2, S3, S4, S5, S6} state_t;
  logic [2:0] state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, dur_m1;
  logic legal, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    legal   = state <= S6;
    dur_m1  = state == S1 ? CNT_W'(T_MAIN - 1) :
              state == S3 ? CNT_W'(T_TURN - 1) :
              state == S5 ? CNT_W'(T_SIDE - 1) : CNT_W'(T_YEL - 1);
    last    = cnt == dur_m1;
    state_n = !legal || (last && state == S6) ? S1 : last ? state + 3'd1 : state;
    cnt_n   = !legal || last ? '0 : cnt + CNT_W'(1);
    {light_M1, light_M2, light_MT, light_S} =
      state == S1 ? {GRN, GRN, RED, RED} :
      state == S2 ? {GRN, YEL, RED, RED} :
      state == S3 ? {GRN, RED, GRN, RED} :
      state == S4 ? {YEL, RED, YEL, RED} :
      state == S5 ? {RED, RED, RED, GRN} :
      state == S6 ? {RED, RED, RED, YEL} : {RED, RED, RED, RED};
  end
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: randomized-reset scoreboard bench against a phase-table model
module tb_traffic_light_controller;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] light_M1, light_S, light_MT, light_M2;
  int checks = 0, errors = 0;
  int t = 0;
  int period = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e, mon_a;
  int dur[6] = '{7, 2, 5, 2, 3, 2};
  logic [11:0] pat[6] = '{{G, G, R, R}, {G, Y, R, R}, {G, R, G, R},
                          {Y, R, Y, R}, {R, R, R, G}, {R, R, R, Y}};
  always #5 clk = ~clk;
  traffic_light_controller dut (
    .clk(clk), .rst(rst),
    .light_M1(light_M1), .light_S(light_S), .light_MT(light_MT), .light_M2(light_M2)
  );
  function automatic logic [11:0] expect_at(int tt);
    int r = tt;
    for (int p = 0; p < 6; p++) begin
      if (r < dur[p]) return pat[p];
      r -= dur[p];
    end
    return {R, R, R, R};
  endfunction
  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    t = r ? 0 : (t + 1) % period;
    exp_q.push_back(expect_at(t));
  endtask
  task automatic check_all_red(input string name);
    #1;
    checks++;
    if ({light_M1, light_M2, light_MT, light_S} !== {R, R, R, R}) begin
      errors++;
      $display("FAIL %s: got M1/M2/MT/S=%b required %b", name,
               {light_M1, light_M2, light_MT, light_S}, {R, R, R, R});
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {light_M1, light_M2, light_MT, light_S};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL lights @%0t: got M1/M2/MT/S=%b required %b", $time, mon_a, mon_e);
      end
      checks++;
      if ((light_S !== R && (light_M1 !== R || light_M2 !== R || light_MT !== R)) ||
          (light_MT !== R && light_M2 !== R)) begin
        errors++;
        $display("FAIL safety @%0t: got M1/M2/MT/S=%b required no conflicting greens", $time, mon_a);
      end
    end
  end
  initial begin
    for (int p = 0; p < 6; p++) period += dur[p];
    step(1'b1);
    repeat (200) step(1'b0);
    while (t != 11) step(1'b0);
    step(1'b1);
    repeat (25) step(1'b0);
    repeat (300) step($urandom_range(0, 29) == 0);
    @(negedge clk);
    rst = 1'b0;
    force dut.state = 3'b110;
    check_all_red("illegal_110");
    release dut.state;
    t = 0;
    exp_q.push_back(expect_at(0));
    repeat (12) step(1'b0);
    @(negedge clk);
    force dut.state = 3'b111;
    check_all_red("illegal_111");
    release dut.state;
    t = 0;
    exp_q.push_back(expect_at(0));
    repeat (25) step(1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
